// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: access modes, lock FSM states, request payload.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_mode_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    // Mode is kept as raw bits so the reserved encoding 2'b11 passes through untouched.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MODE_W-1:0] mode;
        logic              uns;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } port_req_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-input round-robin selector: masks requests by eligibility, breaks ties against last_gnt.
module dmem_rr_pick (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic [1:0] eligible,
    output logic [1:0] gnt_c
);

    logic [1:0] cand;

    always_comb begin
        cand  = req & eligible;
        gnt_c = 2'b00;
        if (cand == 2'b11) begin
            gnt_c = last_gnt ? 2'b01 : 2'b10;
        end else begin
            gnt_c = cand;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_memory port between the LSU (port 0) and an auxiliary master (port 1).
// Optional ownership lock is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [MODE_W-1:0] p0_mode,
    input  logic              p0_unsigned,
    input  logic              p0_we,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_lock,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [MODE_W-1:0] p1_mode,
    input  logic              p1_unsigned,
    input  logic              p1_we,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [MODE_W-1:0] mem_mode,
    output logic              mem_unsigned,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    port_req_t  req0;
    port_req_t  req1;
    port_req_t  sel_c;
    logic [1:0] eligible_c;
    logic [1:0] pick_c;
    logic [1:0] gnt_c;
    logic       load_gnt_c;

    logic       last_gnt;
    logic       rsp_valid;
    logic       rsp_port;
    logic       rsp_unsigned;

    assign req0 = {p0_addr, p0_mode, p0_unsigned, p0_we, p0_wdata};
    assign req1 = {p1_addr, p1_mode, p1_unsigned, p1_we, p1_wdata};

    dmem_rr_pick u_pick (
        .req      ({p1_req, p0_req}),
        .last_gnt (last_gnt),
        .eligible (eligible_c),
        .gnt_c    (pick_c)
    );

    // Nothing is issued while reset is held.
    assign gnt_c  = reset ? pick_c : 2'b00;
    assign p0_gnt = gnt_c[0];
    assign p1_gnt = gnt_c[1];

    // Memory port mux; idle cycles present a benign word read of address 0.
    always_comb begin
        sel_c       = gnt_c[1] ? req1 : req0;
        mem_address = '0;
        mem_mode    = MEM_WORD;
        mem_data    = '0;
        mem_wren    = 1'b0;
        load_gnt_c  = 1'b0;
        if (|gnt_c) begin
            mem_address = sel_c.addr;
            mem_mode    = sel_c.mode;
            mem_data    = sel_c.wdata;
            mem_wren    = sel_c.we;
            load_gnt_c  = ~sel_c.we;
        end
    end

    // Response tracking and round-robin history.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_valid    <= 1'b0;
            rsp_port     <= 1'b0;
            rsp_unsigned <= 1'b0;
            last_gnt     <= 1'b1;
        end else begin
            rsp_valid <= load_gnt_c;
            if (load_gnt_c) begin
                rsp_port     <= gnt_c[1];
                rsp_unsigned <= sel_c.uns;
            end
            if (|gnt_c) begin
                last_gnt <= gnt_c[1];
            end
        end
    end

    // The memory sign-extends at its output stage, so the flag follows the response, not the issue.
    assign mem_unsigned = reset & rsp_unsigned;
    assign p0_rvalid    = reset & rsp_valid & ~rsp_port;
    assign p1_rvalid    = reset & rsp_valid & rsp_port;
    assign p0_rdata     = p0_rvalid ? mem_q : '0;
    assign p1_rdata     = p1_rvalid ? mem_q : '0;

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_nxt;
    logic             timeout_c;

    assign timeout_c = (idle_cnt == CNT_W'(LOCK_TIMEOUT));

    // Eligibility depends only on registered state, keeping the grant path loop-free.
    always_comb begin
        eligible_c = 2'b11;
        if (!timeout_c) begin
            case (state)
                ARB_OWN0: eligible_c = 2'b01;
                ARB_OWN1: eligible_c = 2'b10;
                default:  eligible_c = 2'b11;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        case (state)
            ARB_IDLE: begin
                idle_cnt_nxt = '0;
                if (gnt_c[0] && p0_lock) begin
                    state_nxt = ARB_OWN0;
                end else if (gnt_c[1] && p1_lock) begin
                    state_nxt = ARB_OWN1;
                end
            end
            ARB_OWN0: begin
                if (timeout_c || (gnt_c[0] && !p0_lock) || (!p0_req && !p0_lock)) begin
                    state_nxt    = ARB_IDLE;
                    idle_cnt_nxt = '0;
                end else if (gnt_c[0]) begin
                    idle_cnt_nxt = '0;
                end else begin
                    idle_cnt_nxt = idle_cnt + CNT_W'(1);
                end
            end
            ARB_OWN1: begin
                if (timeout_c || (gnt_c[1] && !p1_lock) || (!p1_req && !p1_lock)) begin
                    state_nxt    = ARB_IDLE;
                    idle_cnt_nxt = '0;
                end else if (gnt_c[1]) begin
                    idle_cnt_nxt = '0;
                end else begin
                    idle_cnt_nxt = idle_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = ARB_IDLE;
                idle_cnt_nxt = '0;
            end
        endcase
    end
`else
    logic unused_lock;

    assign eligible_c  = 2'b11;
    assign unused_lock = ^{p0_lock, p1_lock, 32'(LOCK_TIMEOUT)};
`endif

endmodule
